// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder built from one full-adder cell and a carry
// flip-flop. Operands are captured in parallel on an accepted start, added
// LSB-first at one bit per clock, and the parallel sum/carry-out are returned
// with a one-cycle done pulse. Latency is WIDTH cycles from the accepted
// start edge; back-to-back operation gives one result per WIDTH+1 cycles.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
//   When defined, the ovf port and register exist and report two's-complement
//   overflow of a+b+cin, held alongside sum/cout.
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 2)
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  operation request; sampled only when not busy
//   a, b   operands, captured on the accepted start edge
//   cin    carry-in, captured on the accepted start edge
//   busy   high while bits are being added
//   done   one-cycle pulse; sum/cout (and ovf) valid
//   sum    result, held until the next accepted start
//   cout   carry-out, held with sum
//   ovf    signed overflow (only with SERIAL_ADDER_OVF_EN)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;

  // The single full-adder cell, fed from the LSBs of the operand shift
  // registers and the carry flip-flop.
  logic s_bit;
  logic carry_next;
  logic accept;

  // start is only honoured outside SHIFT so an operation in flight is never
  // disturbed; DONE accepts it to allow back-to-back operation.
  always_comb begin
    s_bit      = a_sr[0] ^ b_sr[0] ^ carry;
    carry_next = (a_sr[0] & b_sr[0]) | (b_sr[0] & carry) | (carry & a_sr[0]);
    accept     = start && (state != SHIFT);
  end

  // Control FSM and datapath registers in one block so every output is
  // registered. The sum register fills from the top, so after WIDTH shifts
  // bit 0 of the result has arrived at sum[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      carry <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        state <= SHIFT;
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        count <= '0;
        sum   <= '0;
        cout  <= 1'b0;
        busy  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
        ovf   <= 1'b0;
`endif
      end else if (state == SHIFT) begin
        sum   <= {s_bit, sum[WIDTH-1:1]};
        a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
        carry <= carry_next;
        if (count == LAST_BIT) begin
          // Final bit: the carry into the MSB is the current carry, the carry
          // out of it is carry_next; their XOR is signed overflow.
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          cout  <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
          ovf   <= carry ^ carry_next;
`endif
        end else begin
          count <= count + CW'(1);
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule
